// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM states and the access-legality / store-lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Unsigned loads have no store counterpart, and sizes must be naturally aligned.
    function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = BE_ALL;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = BE_ALL;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts the bus word down by the byte offset and
// produces the five sign/zero-extended load-result candidates.
module load_align (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_word,
    output logic [31:0] o_byte_s,
    output logic [31:0] o_byte_u,
    output logic [31:0] o_half_s,
    output logic [31:0] o_half_u
);

    logic [31:0] w_lane;

    assign w_lane   = i_rdata >> {i_offset, 3'b000};
    assign o_word   = i_rdata;
    assign o_byte_s = {{24{w_lane[7]}}, w_lane[7:0]};
    assign o_byte_u = {24'h000000, w_lane[7:0]};
    assign o_half_s = {{16{w_lane[15]}}, w_lane[15:0]};
    assign o_half_u = {16'h0000, w_lane[15:0]};

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues one ack-handshaked bus access per legal
// request, stalls the pipeline meanwhile and registers the load candidates.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] ld_word,
    output logic [31:0] ld_byte_s,
    output logic [31:0] ld_half_s,
    output logic [31:0] ld_byte_u,
    output logic [31:0] ld_half_u,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [1:0]  r_offset;
    logic [CNT_W-1:0] r_cnt;
    logic        r_is_load;
    logic        r_bus_err;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_ld_word, r_ld_byte_s, r_ld_byte_u, r_ld_half_s, r_ld_half_u;

    logic        w_valid, w_is_load, w_legal, w_timeout;
    logic        w_stall, w_misaligned, w_start;
    logic [31:0] w_word, w_byte_s, w_byte_u, w_half_s, w_half_u;

    // A simultaneous read and write request is handled as a read.
    assign w_valid   = mem_read | mem_write;
    assign w_is_load = mem_read;
    assign w_legal   = access_legal(w_is_load, funct3, addr[1:0]);
    assign w_timeout = (r_cnt == CNT_LAST);

    load_align u_align (
        .i_rdata  (bus_rdata),
        .i_offset (r_offset),
        .o_word   (w_word),
        .o_byte_s (w_byte_s),
        .o_byte_u (w_byte_u),
        .o_half_s (w_half_s),
        .o_half_u (w_half_u)
    );

    // Next-state and combinational stall/misaligned decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_stall      = 1'b0;
        w_misaligned = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid && w_legal) begin
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = WAIT;
                end else if (w_valid) begin
                    w_misaligned = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus request registers, timeout counter and load-result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset    <= 2'b00;
            r_cnt       <= {CNT_W{1'b0}};
            r_is_load   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_ld_word   <= 32'h0000_0000;
            r_ld_byte_s <= 32'h0000_0000;
            r_ld_byte_u <= 32'h0000_0000;
            r_ld_half_s <= 32'h0000_0000;
            r_ld_half_u <= 32'h0000_0000;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= ~w_is_load;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= w_is_load ? BE_ALL : store_be(funct3, addr[1:0]);
                        r_bus_wdata <= w_is_load ? 32'h0000_0000 : store_lanes(funct3, store_data);
                        r_offset    <= addr[1:0];
                        r_cnt       <= {CNT_W{1'b0}};
                        r_is_load   <= w_is_load;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (r_is_load) begin
                            r_ld_word   <= w_word;
                            r_ld_byte_s <= w_byte_s;
                            r_ld_byte_u <= w_byte_u;
                            r_ld_half_s <= w_half_s;
                            r_ld_half_u <= w_half_u;
                        end
                    end else if (w_timeout) begin
                        // An aborted load must not leave stale data behind.
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (r_is_load) begin
                            r_ld_word   <= 32'h0000_0000;
                            r_ld_byte_s <= 32'h0000_0000;
                            r_ld_byte_u <= 32'h0000_0000;
                            r_ld_half_s <= 32'h0000_0000;
                            r_ld_half_u <= 32'h0000_0000;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DONE:    r_bus_req <= 1'b0;
                default: r_bus_req <= 1'b0;
            endcase
        end
    end

    assign stall      = w_stall & ~rst;
    assign misaligned = w_misaligned & ~rst;
    assign bus_err    = r_bus_err;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;
    assign ld_word    = r_ld_word;
    assign ld_byte_s  = r_ld_byte_s;
    assign ld_byte_u  = r_ld_byte_u;
    assign ld_half_s  = r_ld_half_s;
    assign ld_half_u  = r_ld_half_u;

endmodule
